norm_seq_ctrl: RTL and testbench
================================

Name: norm_seq_ctrl

Overview:
- Sequences one vector-norm accumulation through the squared-sum datapath. That datapath computes x*x + y*y combinationally, and an external accumulator fp_adder adds that result to the running sum.
- Accepts a start command with a vector length, then accepts element pairs over a valid/ready stream.
- Registers each pair onto the ALU operand bus and owns the accumulator register.
- Returns the 39-bit sum of squares over a result valid/ready handshake.
- Sits between the vector source (memory/ingress) and the sqrt/output stage.

Parameters:
- LEN_W, 8, width of vec_len and the internal element counters; max vector length 2^LEN_W-1.
- PAD_ZERO, 24'h000000, operand value substituted for y on the final pair of an odd-length vector; this encoding is +0.0 in the 24-bit format.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new vector; sampled only in IDLE
- vec_len  in  LEN_W  number of elements (not pairs), latched on start
- in_valid  in  1  element pair valid
- in_ready  out  1  controller accepts pair this cycle
- in_x  in  24  element 2k
- in_y  in  24  element 2k+1; ignored on an odd tail pair
- alu_x  out  24  registered operand to FP_ALU x
- alu_y  out  24  registered operand to FP_ALU y
- acc_sum  in  39  output of the external accumulator adder, equal to sum_sq(alu_x, alu_y) + acc_q
- acc_q  out  39  accumulator register, fed back to the accumulator adder
- busy  out  1  high in any state except IDLE
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- result  out  39  equal to acc_q while out_valid

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - alu_x, alu_y, acc_q = 0.
  - op_vld=0; pairs_left=0; odd_tail=0.
  - in_ready, out_valid, busy = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1: latch pairs_left=ceil(vec_len/2) and odd_tail=vec_len[0]; clear acc_q to 0.
  - If vec_len=0, go to DONE. Otherwise go to RUN.
  - start outside IDLE is ignored.
- RUN:
  - in_ready=1 while pairs_left>0.
  - Transfer occurs when in_valid && in_ready.
  - On transfer: alu_x<=in_x; alu_y<=in_y, or PAD_ZERO if this is the last pair and odd_tail=1; op_vld<=1; pairs_left decrements.
  - The transfer of the last pair moves the state to DRAIN.
- Accumulate:
  - Every edge with op_vld=1 performs acc_q<=acc_sum.
  - op_vld clears on any edge with no transfer.
  - alu_x/alu_y hold their value when there is no transfer.
  - Back-to-back transfers produce one accumulate per cycle. The datapath is combinational, so there is no hazard.
- DRAIN: lasts exactly one cycle; the final accumulate occurs on its edge; then go to DONE.
- Latency: last pair accepted in cycle t → operands valid in cycle t+1 → acc_q final and out_valid=1 in cycle t+2.
- DONE:
  - out_valid=1 and result=acc_q, both held stable until out_ready=1.
  - On the handshake edge go to IDLE. Values are retained until the next start.
  - out_ready high in the same cycle out_valid first rises completes the handshake in that cycle.
- in_ready=0 in IDLE, DRAIN and DONE.
- in_valid bubbles in RUN stall without penalty; counters are unchanged.
- vec_len=1: one pair with y padded; result = x^2.
- vec_len=2^LEN_W-1: pairs_left=2^(LEN_W-1), and odd_tail=1.
- Reset mid-operation: immediate return to IDLE with all registers cleared. Any partial sum is discarded; no out_valid is produced.

Test Plan:
- Bench uses an integer stub: acc_sum = acc_q + alu_x^2 + alu_y^2.
- Reset, then start with vec_len=4, pairs (1,2),(3,4) sent back-to-back → in_ready high for exactly 2 transfers; out_valid 2 cycles after the second transfer; result=30.
- vec_len=3, pairs (2,5),(7,9) → alu_y=0 on the tail pair; result=78; the 9 is never accumulated.
- vec_len=0 → DONE the cycle after start; result=0; in_ready never asserts.
- vec_len=4 with in_valid toggling every other cycle, then out_ready held low 5 cycles → result=30 held stable throughout; start pulses during busy are ignored; IDLE follows the out_ready edge.
- rst_n low after the first pair of a vec_len=6 vector → all outputs 0 asynchronously; a fresh vec_len=2 vector (3,4) afterwards → result=25.
- Consecutive vectors with no idle gap (start the cycle after the result handshake) → acc_q cleared; second result is independent of the first.

Source files
------------

// File: rtl/norm_seq_ctrl.sv
// norm_seq_ctrl
// -------------
// Control sequencer for one sum-of-squares accumulation. The squared-sum
// datapath (x*x + y*y) and the accumulator adder live outside this block.
// This block sets up the adder inputs and keeps the running sum.
//
// For each vector:
//   1. A start command latches the element count.
//   2. Element pairs are accepted over a valid/ready stream.
//   3. Each accepted pair is registered onto the ALU operand bus.
//   4. The adder output (acc_sum) is folded into the accumulator register.
//   5. The final 39-bit sum is returned over a valid/ready result handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, vec_len    start a vector of vec_len elements (sampled in IDLE only)
//   in_valid/in_ready element-pair stream handshake
//   in_x, in_y        element 2k / 2k+1 (in_y ignored on an odd tail pair)
//   alu_x, alu_y      registered operands driven to the squared-sum datapath
//   acc_sum           external adder output = sum_sq(alu_x, alu_y) + acc_q
//   acc_q             accumulator register, fed back to the external adder
//   busy              high whenever the sequencer is not IDLE
//   out_valid/ready   result handshake
//   result            final sum, equal to acc_q while out_valid is high
module norm_seq_ctrl #(
    parameter int          LEN_W    = 8,
    parameter logic [23:0] PAD_ZERO = 24'h000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_x,
    input  logic [23:0]      in_y,
    output logic [23:0]      alu_x,
    output logic [23:0]      alu_y,
    input  logic [38:0]      acc_sum,
    output logic [38:0]      acc_q,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [38:0]      result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] pairs_left_q, pairs_left_d;
    logic             odd_tail_q, odd_tail_d;
    logic             op_vld_q, op_vld_d;
    logic [23:0]      alu_x_q, alu_x_d;
    logic [23:0]      alu_y_q, alu_y_d;
    logic [38:0]      accum_q, accum_d;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             last_pair;

    // The pair currently offered is the last one when exactly one remains.
    assign last_pair = (pairs_left_q == {{(LEN_W-1){1'b0}}, 1'b1});

    always_comb begin
        state_d      = state_q;
        pairs_left_d = pairs_left_q;
        odd_tail_d   = odd_tail_q;
        alu_x_d      = alu_x_q;
        alu_y_d      = alu_y_q;
        op_vld_d     = 1'b0;
        // A valid operand pair on the bus means acc_sum already holds
        // its contribution added to the running total.
        accum_d      = op_vld_q ? acc_sum : accum_q;
        in_ready_c   = 1'b0;
        out_valid_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // pairs = ceil(len/2). This form cannot overflow LEN_W
                    // bits, even for the maximum length.
                    pairs_left_d = (vec_len >> 1) + {{(LEN_W-1){1'b0}}, vec_len[0]};
                    odd_tail_d   = vec_len[0];
                    accum_d      = '0;
                    state_d      = (vec_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready_c = (pairs_left_q != '0);
                if (in_valid && in_ready_c) begin
                    alu_x_d      = in_x;
                    // An odd vector has no element 2k+1 on its tail pair.
                    // Substitute +0.0 so that slot adds nothing.
                    alu_y_d      = (last_pair && odd_tail_q) ? PAD_ZERO : in_y;
                    op_vld_d     = 1'b1;
                    pairs_left_d = pairs_left_q - 1'b1;
                    if (last_pair) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last operand pair is folded in on this edge.
                state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pairs_left_q <= '0;
            odd_tail_q   <= 1'b0;
            op_vld_q     <= 1'b0;
            alu_x_q      <= '0;
            alu_y_q      <= '0;
            accum_q      <= '0;
        end else begin
            state_q      <= state_d;
            pairs_left_q <= pairs_left_d;
            odd_tail_q   <= odd_tail_d;
            op_vld_q     <= op_vld_d;
            alu_x_q      <= alu_x_d;
            alu_y_q      <= alu_y_d;
            accum_q      <= accum_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_c;
    assign busy      = (state_q != IDLE);
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign acc_q     = accum_q;
    assign result    = accum_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
module tb_norm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_x;
    logic [23:0] in_y;
    logic [23:0] alu_x;
    logic [23:0] alu_y;
    logic [38:0] acc_sum;
    logic [38:0] acc_q;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [38:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [38:0] exp_q[$];
    int          px[0:127];
    int          py[0:127];

    norm_seq_ctrl #(.LEN_W(8), .PAD_ZERO(24'h000000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .acc_sum   (acc_sum),
        .acc_q     (acc_q),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Integer stand-in for the squared-sum datapath and accumulator adder.
    logic [38:0] ax, ay;
    assign ax      = {15'd0, alu_x};
    assign ay      = {15'd0, alu_y};
    assign acc_sum = acc_q + ax * ax + ay * ay;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] model(input int len);
        longint s = 0;
        for (int i = 0; i < len; i++) begin
            longint e = (i % 2 == 0) ? px[i / 2] : py[i / 2];
            s += e * e;
        end
        return s[38:0];
    endfunction

    task automatic do_start(input int len, input bit push);
        if (push) exp_q.push_back(model(len));
        vec_len = len[7:0];
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("busy_after_start", busy, 1);
        check("acc_cleared_on_start", acc_q, 0);
        if (len == 0) begin
            check("len0_done_next_cycle", out_valid, 1);
            check("len0_in_ready_low", in_ready, 0);
        end else begin
            check("in_ready_in_run", in_ready, 1);
        end
    endtask

    task automatic feed(input int len, input bit gap, input bit start_noise);
        int  npairs = (len + 1) / 2;
        int  k      = 0;
        int  cyc    = 0;
        bit  xfer;
        while (k < npairs && cyc < 1000) begin
            in_valid = gap ? (cyc % 2 == 1) : 1'b1;
            start    = start_noise;
            vec_len  = 8'd2;
            in_x     = px[k][23:0];
            in_y     = py[k][23:0];
            xfer     = in_valid && in_ready;
            tick();
            cyc++;
            if (xfer) k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("pairs_transferred", k, npairs);
        check("tail_alu_x", alu_x, px[npairs-1][23:0]);
        check("tail_alu_y", alu_y, (len % 2 == 1) ? 24'd0 : py[npairs-1][23:0]);
        check("in_ready_low_in_drain", in_ready, 0);
        check("out_valid_low_in_drain", out_valid, 0);
        tick();
        check("out_valid_two_after_last", out_valid, 1);
    endtask

    task automatic collect(input int hold, input bit start_noise);
        logic [38:0] expv;
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("out_valid_wait", out_valid, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            expv = '0;
        end else begin
            expv = exp_q.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = start_noise;
            vec_len   = 8'd3;
            check("result_held", result, expv);
            check("out_valid_held", out_valid, 1);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("result", result, expv);
        tick();
        out_ready = 1'b0;
        check("out_valid_cleared", out_valid, 0);
        check("idle_after_handshake", busy, 0);
        check("result_retained", result, expv);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_q", acc_q, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_y", alu_y, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Even length, back-to-back pairs: 1+4+9+16 = 30
        px[0] = 1; py[0] = 2; px[1] = 3; py[1] = 4;
        do_start(4, 1);
        feed(4, 0, 0);
        collect(0, 0);

        // Odd length: the trailing 9 must be padded to zero, 4+25+49 = 78
        px[0] = 2; py[0] = 5; px[1] = 7; py[1] = 9;
        do_start(3, 1);
        feed(3, 0, 0);
        collect(0, 0);

        // Zero length goes straight to DONE with a zero result
        do_start(0, 1);
        collect(0, 0);

        // Bubbles on in_valid, start noise while busy, result held 5 cycles
        px[0] = 1; py[0] = 2; px[1] = 3; py[1] = 4;
        do_start(4, 1);
        feed(4, 1, 1);
        collect(5, 1);

        // Reset in the middle of a vector discards the partial sum
        px[0] = 1; py[0] = 2;
        do_start(6, 0);
        in_valid = 1'b1; in_x = 24'd1; in_y = 24'd2;
        tick();
        in_valid = 1'b0;
        tick();
        check("partial_sum_before_reset", acc_q, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_acc_q", acc_q, 0);
        check("async_rst_alu_x", alu_x, 0);
        check("async_rst_alu_y", alu_y, 0);
        check("async_rst_result", result, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        px[0] = 3; py[0] = 4;
        do_start(2, 1);
        feed(2, 0, 0);
        collect(0, 0);

        // Back-to-back vectors with no idle gap: 25+36 = 61, then 1+1 = 2
        px[0] = 5; py[0] = 6;
        do_start(2, 1);
        feed(2, 0, 0);
        collect(0, 0);
        px[0] = 1; py[0] = 1;
        do_start(2, 1);
        feed(2, 0, 0);
        collect(0, 0);

        // Maximum length: 128 pairs with the tail y padded
        for (int i = 0; i < 128; i++) begin
            px[i] = (i % 5) + 1;
            py[i] = (i % 3) + 2;
        end
        do_start(255, 1);
        feed(255, 0, 0);
        collect(0, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
